// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter with bounded lock in front of a 1-cycle sync RAM.
// Define RAM_ARB_B_PRIORITY_EN for fixed B priority (a_lock ignored).
module ram_arbiter #(
  parameter int A        = 10,
  parameter int D        = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         a_req,
  input  logic         a_rw,
  input  logic         a_lock,
  input  logic [A-1:0] a_addr,
  input  logic [D-1:0] a_di,
  output logic         a_gnt,
  output logic         a_rvalid,
  output logic [D-1:0] a_dout,
  input  logic         b_req,
  input  logic         b_rw,
  input  logic         b_lock,
  input  logic [A-1:0] b_addr,
  input  logic [D-1:0] b_di,
  output logic         b_gnt,
  output logic         b_rvalid,
  output logic [D-1:0] b_dout,
  output logic         ram_cs,
  output logic         ram_rw,
  output logic [A-1:0] ram_addr,
  output logic [D-1:0] ram_di,
  input  logic [D-1:0] ram_dout
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LMAX = CW'(LOCK_MAX);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_A,
    OWN_B
  } owner_t;

  owner_t        owner;
  owner_t        win_owner;
  logic [CW-1:0] lock_cnt;
  logic [CW-1:0] cnt_nxt;
  logic          last_b;
  logic          a_rd_q;
  logic          b_rd_q;
  logic          a_lk;
  logic          conflict_b;
  logic          lock_live;
  logic          win_lock;

`ifdef RAM_ARB_B_PRIORITY_EN
  assign a_lk       = 1'b0;
  assign conflict_b = 1'b1;
`else
  assign a_lk       = a_lock;
  assign conflict_b = ~last_b;
`endif

  // cnt never rests at LMAX: reaching it releases the lock at once
  assign lock_live = (owner != OWN_NONE) && (lock_cnt < LMAX);

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!reset) begin
      if (lock_live && owner == OWN_A && a_req) begin
        a_gnt = 1'b1;
      end else if (lock_live && owner == OWN_B && b_req) begin
        b_gnt = 1'b1;
      end else if (a_req && b_req) begin
        b_gnt = conflict_b;
        a_gnt = ~conflict_b;
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  always_comb begin
    ram_rw   = 1'b0;
    ram_addr = '0;
    ram_di   = '0;
    unique case (1'b1)
      a_gnt: begin
        ram_rw   = a_rw;
        ram_addr = a_addr;
        ram_di   = a_di;
      end
      b_gnt: begin
        ram_rw   = b_rw;
        ram_addr = b_addr;
        ram_di   = b_di;
      end
      default: ;
    endcase
  end

  assign ram_cs = a_gnt | b_gnt;

  assign win_owner = a_gnt ? OWN_A : OWN_B;
  assign win_lock  = (a_gnt & a_lk) | (b_gnt & b_lock);
  assign cnt_nxt   = (owner == win_owner) ? lock_cnt + 1'b1 : CW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      owner    <= OWN_NONE;
      lock_cnt <= '0;
      last_b   <= 1'b1;
      a_rd_q   <= 1'b0;
      b_rd_q   <= 1'b0;
    end else begin
      a_rd_q <= a_gnt & ~a_rw;
      b_rd_q <= b_gnt & ~b_rw;
      if (a_gnt | b_gnt) begin
        last_b <= b_gnt;
      end
      // idle cycle or unlocked grant both drop the lock
      if (win_lock && cnt_nxt != LMAX) begin
        owner    <= win_owner;
        lock_cnt <= cnt_nxt;
      end else begin
        owner    <= OWN_NONE;
        lock_cnt <= '0;
      end
    end
  end

  // reset in the return cycle drops in-flight read data
  assign a_rvalid = a_rd_q & ~reset;
  assign b_rvalid = b_rd_q & ~reset;
  assign a_dout   = a_rvalid ? ram_dout : '0;
  assign b_dout   = b_rvalid ? ram_dout : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: vector table for grants, read-data scoreboard
// against a shadow memory, plus a randomized alternating-conflict sequence.
module tb_ram_arbiter;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_req, a_rw, a_lock;
  logic [9:0] a_addr;
  logic [7:0] a_di;
  logic       a_gnt, a_rvalid;
  logic [7:0] a_dout;
  logic       b_req, b_rw, b_lock;
  logic [9:0] b_addr;
  logic [7:0] b_di;
  logic       b_gnt, b_rvalid;
  logic [7:0] b_dout;
  logic       ram_cs, ram_rw;
  logic [9:0] ram_addr;
  logic [7:0] ram_di;
  logic [7:0] ram_dout;

  ram_arbiter #(.A(10), .D(8), .LOCK_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_rw(a_rw), .a_lock(a_lock),
    .a_addr(a_addr), .a_di(a_di),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_dout(a_dout),
    .b_req(b_req), .b_rw(b_rw), .b_lock(b_lock),
    .b_addr(b_addr), .b_di(b_di),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_dout(b_dout),
    .ram_cs(ram_cs), .ram_rw(ram_rw),
    .ram_addr(ram_addr), .ram_di(ram_di),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] seed(input int i);
    logic [7:0] v;
    v = 8'(i * 7 + 3);
    if (i == 16) v = 8'h5A;
    return v;
  endfunction

  // RAM model: registered read, write on edge
  logic [7:0] mem [0:1023];
  logic       mem_init;
  always @(posedge clk) begin
    if (mem_init !== 1'b1) begin
      for (int i = 0; i < 1024; i++) mem[i] <= seed(i);
      mem_init <= 1'b1;
    end else if (ram_cs) begin
      if (ram_rw) mem[ram_addr] <= ram_di;
      else ram_dout <= mem[ram_addr];
    end
  end

  typedef struct {
    logic       rst;
    logic       ar, arw, al;
    logic [9:0] aa;
    logic [7:0] ad;
    logic       br, brw, bl;
    logic [9:0] ba;
    logic [7:0] bd;
    logic       ega, egb;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] shadow [0:1023];
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic       pend_a, pend_b;
  int         checks = 0;
  int         errors = 0;

  function automatic vec_t mk(
    input logic rst, ar, arw, al, input logic [9:0] aa, input logic [7:0] ad,
    input logic br, brw, bl, input logic [9:0] ba, input logic [7:0] bd,
    input logic ega, egb);
    vec_t v;
    v.rst = rst; v.ar = ar; v.arw = arw; v.al = al; v.aa = aa; v.ad = ad;
    v.br = br; v.brw = brw; v.bl = bl; v.ba = ba; v.bd = bd;
    v.ega = ega; v.egb = egb;
    return v;
  endfunction

  task automatic chk1(input string nm, input int row, input logic act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %b want %b", nm, row, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input int row, input logic [7:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
    end
  endtask

  task automatic chk10(input string nm, input int row, input logic [9:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
    end
  endtask

  task automatic rv_check(input int row, input logic rst, input logic pend,
                          input logic rv, input logic [7:0] dout,
                          input string nm, inout logic [7:0] q[$]);
    chk1({nm, "_rvalid"}, row, rv, pend & ~rst);
    if (rv) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL %s_unexpected row %0d: got rvalid 1 want 0", nm, row);
      end else begin
        chk8({nm, "_dout"}, row, dout, q.pop_front());
      end
    end else begin
      chk8({nm, "_dout_idle"}, row, dout, 8'h00);
      if (pend && q.size() > 0) void'(q.pop_front());
    end
  endtask

  task automatic step(input int row, input vec_t v);
    @(posedge clk);
    #1;
    reset = v.rst;
    a_req = v.ar; a_rw = v.arw; a_lock = v.al; a_addr = v.aa; a_di = v.ad;
    b_req = v.br; b_rw = v.brw; b_lock = v.bl; b_addr = v.ba; b_di = v.bd;
    @(negedge clk);
    chk1("a_gnt", row, a_gnt, v.ega);
    chk1("b_gnt", row, b_gnt, v.egb);
    chk1("ram_cs", row, ram_cs, v.ega | v.egb);
    if (v.ega) begin
      chk10("ram_addr_a", row, ram_addr, v.aa);
      chk1("ram_rw_a", row, ram_rw, v.arw);
    end
    if (v.egb) begin
      chk10("ram_addr_b", row, ram_addr, v.ba);
      chk1("ram_rw_b", row, ram_rw, v.brw);
    end
    rv_check(row, v.rst, pend_a, a_rvalid, a_dout, "a", qa);
    rv_check(row, v.rst, pend_b, b_rvalid, b_dout, "b", qb);
    pend_a = v.ega & ~v.arw;
    pend_b = v.egb & ~v.brw;
    if (pend_a) qa.push_back(shadow[v.aa]);
    if (pend_b) qb.push_back(shadow[v.ba]);
    if (v.ega && v.arw) shadow[v.aa] = v.ad;
    if (v.egb && v.brw) shadow[v.ba] = v.bd;
  endtask

  task automatic idle_row(input int row, input logic rst);
    step(row, mk(rst, L, L, L, 10'h0, 8'h0, L, L, L, 10'h0, 8'h0, L, L));
  endtask

  initial begin
    vec_t       v;
    logic [9:0] ra, rb;
    logic       turn_b;
    int         row;
    reset = 1'b1;
    a_req = 0; a_rw = 0; a_lock = 0; a_addr = '0; a_di = '0;
    b_req = 0; b_rw = 0; b_lock = 0; b_addr = '0; b_di = '0;
    pend_a = 0; pend_b = 0;
    for (int i = 0; i < 1024; i++) shadow[i] = seed(i);
    repeat (2) @(posedge clk);

    // requests during reset get nothing
    vecs.push_back(mk(H, H,L,L,10'h010,8'h00, H,L,L,10'h020,8'h00, L,L));
    vecs.push_back(mk(H, H,L,L,10'h010,8'h00, H,L,L,10'h020,8'h00, L,L));
`ifndef RAM_ARB_B_PRIORITY_EN
    vecs.push_back(mk(L, H,L,L,10'h010,8'h00, L,L,L,10'h000,8'h00, H,L));
    vecs.push_back(mk(L, L,L,L,10'h000,8'h00, L,L,L,10'h000,8'h00, L,L));
    vecs.push_back(mk(H, L,L,L,10'h000,8'h00, L,L,L,10'h000,8'h00, L,L));
    // both writing: A first, then alternate
    vecs.push_back(mk(L, H,H,L,10'h100,8'h11, H,H,L,10'h200,8'h22, H,L));
    vecs.push_back(mk(L, H,H,L,10'h101,8'h12, H,H,L,10'h200,8'h22, L,H));
    vecs.push_back(mk(L, H,H,L,10'h101,8'h12, H,H,L,10'h201,8'h23, H,L));
    vecs.push_back(mk(L, H,H,L,10'h102,8'h13, H,H,L,10'h201,8'h23, L,H));
    // A write then B read back
    vecs.push_back(mk(L, H,H,L,10'h3C3,8'hA5, L,L,L,10'h000,8'h00, H,L));
    vecs.push_back(mk(L, L,L,L,10'h000,8'h00, H,L,L,10'h3C3,8'h00, L,H));
    vecs.push_back(mk(L, L,L,L,10'h000,8'h00, L,L,L,10'h000,8'h00, L,L));
    vecs.push_back(mk(L, H,L,L,10'h100,8'h00, L,L,L,10'h000,8'h00, H,L));
    vecs.push_back(mk(L, L,L,L,10'h000,8'h00, H,L,L,10'h200,8'h00, L,H));
    vecs.push_back(mk(L, L,L,L,10'h000,8'h00, H,L,L,10'h201,8'h00, L,H));
    vecs.push_back(mk(L, L,L,L,10'h000,8'h00, L,L,L,10'h000,8'h00, L,L));
    // A locked: 4 grants, forced release to B, then round robin
    vecs.push_back(mk(L, H,H,H,10'h300,8'h40, H,L,L,10'h3C3,8'h00, H,L));
    vecs.push_back(mk(L, H,H,H,10'h301,8'h41, H,L,L,10'h3C3,8'h00, H,L));
    vecs.push_back(mk(L, H,H,H,10'h302,8'h42, H,L,L,10'h3C3,8'h00, H,L));
    vecs.push_back(mk(L, H,H,H,10'h303,8'h43, H,L,L,10'h3C3,8'h00, H,L));
    vecs.push_back(mk(L, H,H,H,10'h304,8'h44, H,L,L,10'h3C3,8'h00, L,H));
    vecs.push_back(mk(L, H,H,L,10'h304,8'h44, H,L,L,10'h201,8'h00, H,L));
    vecs.push_back(mk(L, H,H,L,10'h305,8'h45, H,L,L,10'h201,8'h00, L,H));
    vecs.push_back(mk(L, H,L,L,10'h303,8'h00, L,L,L,10'h000,8'h00, H,L));
    vecs.push_back(mk(L, L,L,L,10'h000,8'h00, L,L,L,10'h000,8'h00, L,L));
    // owner idling one cycle releases the lock
    vecs.push_back(mk(L, H,H,H,10'h306,8'h46, L,L,L,10'h000,8'h00, H,L));
    vecs.push_back(mk(L, L,L,L,10'h000,8'h00, L,L,L,10'h000,8'h00, L,L));
    vecs.push_back(mk(L, H,H,L,10'h307,8'h47, H,L,L,10'h306,8'h00, L,H));
    vecs.push_back(mk(L, H,H,L,10'h307,8'h47, L,L,L,10'h000,8'h00, H,L));
    // reset lands on a read return
    vecs.push_back(mk(L, H,L,L,10'h010,8'h00, L,L,L,10'h000,8'h00, H,L));
    vecs.push_back(mk(H, H,L,L,10'h3C3,8'h00, H,L,L,10'h010,8'h00, L,L));
    vecs.push_back(mk(L, H,L,L,10'h3C3,8'h00, H,L,L,10'h010,8'h00, H,L));
    vecs.push_back(mk(L, H,L,L,10'h100,8'h00, H,L,L,10'h010,8'h00, L,H));
`else
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(L, H,H,H,10'h3E0,8'h77, H,L,L,10'(i),8'h00, L,H));
    vecs.push_back(mk(L, H,H,H,10'h3E0,8'h77, L,L,L,10'h000,8'h00, H,L));
    vecs.push_back(mk(L, L,L,L,10'h000,8'h00, H,L,L,10'h3E0,8'h00, L,H));
`endif
    vecs.push_back(mk(L, L,L,L,10'h000,8'h00, L,L,L,10'h000,8'h00, L,L));
    vecs.push_back(mk(L, L,L,L,10'h000,8'h00, L,L,L,10'h000,8'h00, L,L));

    row = 0;
    foreach (vecs[i]) begin
      step(row, vecs[i]);
      row++;
    end

    // random reads on both ports, held until granted
    idle_row(row, H); row++;
    ra = 10'($urandom_range(0, 1023));
    rb = 10'($urandom_range(0, 1023));
`ifdef RAM_ARB_B_PRIORITY_EN
    turn_b = 1'b1;
`else
    turn_b = 1'b0;
`endif
    for (int i = 0; i < 12; i++) begin
      v = mk(L, H,L,L,ra,8'h00, H,L,L,rb,8'h00, ~turn_b,turn_b);
      step(row, v);
      row++;
      if (turn_b) rb = 10'($urandom_range(0, 1023));
      else ra = 10'($urandom_range(0, 1023));
`ifndef RAM_ARB_B_PRIORITY_EN
      turn_b = ~turn_b;
`endif
    end
    idle_row(row, L); row++;
    idle_row(row, L); row++;

    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending reads want 0/0",
               qa.size(), qb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
